// File: rtl/mips_trace_monitor.sv
// mips_trace_monitor: captures one {pc, alu} record per retired instruction into a FWFT buffer and detects a halted core.
// Optional feature: define TRACE_SEQ_CHECK_EN to count non-sequential PC transitions in jump_cnt.
module mips_trace_monitor #(
   parameter int DEPTH       = 16,
   parameter int STALL_LIMIT = 4,
   parameter int PC_STEP     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                pc_in,
   input  logic [31:0]                alu_in,
   input  logic                       capture_en,
   input  logic                       clear,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [31:0]                rd_pc,
   output logic [31:0]                rd_alu,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       halted,
   output logic [7:0]                 jump_cnt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, CAPTURE, HALTED} state_t;
   state_t        state;
   logic [31:0]   pc_mem  [DEPTH];
   logic [31:0]   alu_mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [31:0]   last_pc;
   logic          have_last;
   logic [7:0]    stall_cnt;
   logic          sample, fresh, wr, pop, full, push;
   // A sample is a new instruction when the PC moved since the last stored one.
   always_comb begin
      sample = state == CAPTURE && capture_en;
      fresh  = !have_last || pc_in != last_pc;
      wr     = sample && fresh;
      pop    = rd_valid && rd_ready;
      full   = count == (AW+1)'(DEPTH);
      push   = wr && (!full || pop);
   end
   assign rd_valid = count != '0;
   assign halted   = state == HALTED;
   assign rd_pc    = rd_valid ? pc_mem[head] : '0;
   assign rd_alu   = rd_valid ? alu_mem[head] : '0;
   // Record storage; contents need no reset since rd_valid gates the outputs.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         pc_mem[tail]  <= pc_in;
         alu_mem[tail] <= alu_in;
      end
   end
   // Buffer pointers, occupancy, sticky flags and capture FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         last_pc   <= '0;
         have_last <= 1'b0;
         stall_cnt <= '0;
      end else if (clear) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         stall_cnt <= '0;
         have_last <= 1'b0;
         if (state == HALTED) state <= IDLE;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (wr && full && !pop) overflow <= 1'b1;
         case (state)
            IDLE: if (capture_en) state <= CAPTURE;
            CAPTURE: begin
               if (!capture_en) begin
                  state     <= IDLE;
                  have_last <= 1'b0;
               end else if (fresh) begin
                  last_pc   <= pc_in;
                  have_last <= 1'b1;
                  stall_cnt <= '0;
               end else begin
                  stall_cnt <= stall_cnt + 8'd1;
                  if (stall_cnt + 8'd1 == 8'(STALL_LIMIT)) state <= HALTED;
               end
            end
            HALTED: if (!capture_en) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`ifdef TRACE_SEQ_CHECK_EN
   // Counts written PCs that do not follow the previous one by PC_STEP, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) jump_cnt <= '0;
      else if (clear) jump_cnt <= '0;
      else if (wr && have_last && pc_in != last_pc + 32'(PC_STEP) && jump_cnt != 8'hff) jump_cnt <= jump_cnt + 8'd1;
   end
`else
   assign jump_cnt = '0;
`endif
endmodule
